mem_access_ctrl: RTL

//  Initiator side of the processor's single-port RAM interface (read/write strobes, 16-bit address,

---
 rtl/mem_access_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port RAM initiator: one request at a time, one-cycle strobes,
// read latency wait, and a held valid/ready response with range checking.
module mem_access_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int MEM_DEPTH = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state, state_nx;
    logic              is_wr, is_wr_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              req_ready_nx;
    logic              rsp_valid_nx;
    logic              rsp_err_nx;
    logic [DATA_W-1:0] rsp_rdata_nx;
    logic              mem_read_nx;
    logic              mem_write_nx;
    logic [ADDR_W-1:0] mem_address_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              accept;
    logic              oor;

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign oor    = 32'(req_addr) >= MEM_DEPTH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            is_wr       <= 1'b0;
            cnt         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_nx;
            is_wr       <= is_wr_nx;
            cnt         <= cnt_nx;
            req_ready   <= req_ready_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_err     <= rsp_err_nx;
            rsp_rdata   <= rsp_rdata_nx;
            mem_read    <= mem_read_nx;
            mem_write   <= mem_write_nx;
            mem_address <= mem_address_nx;
            mem_wdata   <= mem_wdata_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        is_wr_nx        = is_wr;
        cnt_nx          = cnt;
        req_ready_nx    = req_ready;
        rsp_valid_nx    = rsp_valid;
        rsp_err_nx      = rsp_err;
        rsp_rdata_nx    = rsp_rdata;
        mem_read_nx     = 1'b0;
        mem_write_nx    = 1'b0;
        mem_address_nx  = mem_address;
        mem_wdata_nx    = mem_wdata;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    req_ready_nx = 1'b0;
                    is_wr_nx     = req_write;
                    if (oor) begin
                        rsp_valid_nx = 1'b1;
                        rsp_err_nx   = 1'b1;
                        rsp_rdata_nx = '0;
                        state_nx     = RESP;
                    end else begin
                        mem_address_nx = req_addr;
                        mem_wdata_nx   = req_write ? req_wdata : '0;
                        mem_read_nx    = !req_write;
                        mem_write_nx   = req_write;
                        state_nx       = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_nx = CW'(RD_LAT);
                if (is_wr) begin
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b0;
                    rsp_rdata_nx = '0;
                    state_nx     = RESP;
                end else begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                // Last wait cycle: RAM data_out is valid now
                if (cnt == CW'(1)) begin
                    rsp_rdata_nx = mem_rdata;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b0;
                    state_nx     = RESP;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nx = 1'b0;
                    rsp_err_nx   = 1'b0;
                    req_ready_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
